// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor (DIFF = A - B, LSB first) built from two 8-entry truth-table lookups.
// Optional signed-overflow output OVF is enabled by defining SUB_SIGNED_OVF_EN.
module serial_full_subtractor #(
  parameter int unsigned WIDTH    = 8,
  parameter logic [7:0]  DIFF_LUT = 8'h96,
  parameter logic [7:0]  BORR_LUT = 8'h8E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DIFF,
  output logic             Bout,
  output logic             busy,
  output logic             done
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             borrow_r;
  logic [CW-1:0]    cnt_r;
  logic             accept_s;
  logic             last_s;
  logic [2:0]       idx_s;
  logic             d_s;
  logic             bnext_s;

  function automatic logic lut_bit(input logic [7:0] lut, input logic [2:0] idx);
    return lut[idx];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, control strobes and the per-bit truth-table cell
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    idx_s       = {a_sh_r[0], b_sh_r[0], borrow_r};
    d_s         = lut_bit(DIFF_LUT, idx_s);
    bnext_s     = lut_bit(BORR_LUT, idx_s);
    res_nxt_s   = {d_s, res_r[WIDTH-1:1]};
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_CNT) begin
          state_nxt_s = DONE;
          last_s      = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand shifters, borrow chain and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else if (accept_s) begin
      a_sh_r   <= A;
      b_sh_r   <= B;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
    end else if (state_r == RUN) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_r    <= res_nxt_s;
      borrow_r <= bnext_s;
      cnt_r    <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Published result and status; DIFF/Bout only move on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DIFF <= '0;
      Bout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s == RUN) || (state_nxt_s == DONE);
      done <= last_s;
      if (last_s) begin
        DIFF <= res_nxt_s;
        Bout <= bnext_s;
      end else begin
        DIFF <= DIFF;
        Bout <= Bout;
      end
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb_r;
  logic b_msb_r;

  // Operand sign bits are shifted out, so keep them for the overflow check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      if (accept_s) begin
        a_msb_r <= A[WIDTH-1];
        b_msb_r <= B[WIDTH-1];
      end else begin
        a_msb_r <= a_msb_r;
        b_msb_r <= b_msb_r;
      end
      if (last_s) begin
        OVF <= (a_msb_r ^ b_msb_r) & (d_s ^ a_msb_r);
      end else begin
        OVF <= OVF;
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor: directed corner cases, start-ignore,
// held-start re-trigger, mid-run reset and random operands against an arithmetic model.
module tb_serial_full_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] diff;
  logic       bout;
  logic       busy;
  logic       done;
`ifdef SUB_SIGNED_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_diff;
  logic       exp_bout;
  logic       exp_ovf;

  serial_full_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .DIFF  (diff),
    .Bout  (bout),
    .busy  (busy),
    .done  (done)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .OVF   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned/signed arithmetic
  task automatic model(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    int r;
    exp_diff = x - y;
    exp_bout = (x < y);
    sx = $signed(x);
    sy = $signed(y);
    r  = sx - sy;
    exp_ovf = (r > 127) || (r < -128);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_diff"}, diff, exp_diff);
    check({tag, "_bout"}, 8'(bout), 8'(exp_bout));
`ifdef SUB_SIGNED_OVF_EN
    check({tag, "_ovf"}, 8'(ovf), 8'(exp_ovf));
`endif
  endtask

  // One operation with latency, hold-prior-result and pulse-width checks; ends at IDLE
  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
    int c;
    logic [7:0] prev;
    prev = exp_diff;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    check({tag, "_busy_run"}, 8'(busy), 8'd1);
    check({tag, "_hold_prior"}, diff, prev);
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_latency"}, 8'(c), 8'd8);
    model(x, y);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 8'(done), 8'd0);
    check({tag, "_busy_idle"}, 8'(busy), 8'd0);
  endtask

  initial begin
    int pulses;
    int first_at;
    int second_at;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    exp_diff = 8'h00;
    #12;
    check("rst_diff", diff, 8'h00);
    check("rst_bout", 8'(bout), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_diff", diff, 8'h00);
    check("idle_busy", 8'(busy), 8'd0);
    check("idle_done", 8'(done), 8'd0);

    run_op("d05_03", 8'h05, 8'h03);
    run_op("d00_01", 8'h00, 8'h01);
    run_op("d80_01", 8'h80, 8'h01);
    run_op("d7f_ff", 8'h7F, 8'hFF);
    run_op("daa_aa", 8'hAA, 8'hAA);
    run_op("dff_00", 8'hFF, 8'h00);

    // start pulses at RUN cycle 3 and in DONE must be ignored
    @(negedge clk);
    a = 8'h5A; b = 8'h1C; start = 1'b1;
    pulses = 0; first_at = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) begin a = 8'h00; b = 8'h00; end
      if (done) begin pulses++; if (first_at == 0) first_at = i; end
      if (i == 3 || i == 9) begin start = 1'b1; a = 8'hFF; b = 8'h00; end
    end
    start = 1'b0;
    check("ign_pulses", 8'(pulses), 8'd1);
    check("ign_done_at", 8'(first_at), 8'd9);
    model(8'h5A, 8'h1C);
    check_result("ign");

    // held start re-triggers on the first IDLE cycle after DONE
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    first_at = 0; second_at = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (done && first_at == 0) begin
        first_at = i;
        model(8'h10, 8'h20);
        check_result("held1");
        a = 8'h44; b = 8'h11;
      end else if (done) begin
        second_at = i;
        model(8'h44, 8'h11);
        check_result("held2");
      end
      if (i == 11) start = 1'b0;
    end
    check("held_first_at", 8'(first_at), 8'd9);
    check("held_second_at", 8'(second_at), 8'd19);

    // reset at RUN cycle 4 aborts immediately
    @(negedge clk);
    a = 8'h33; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 8'(busy), 8'd0);
    check("mid_rst_diff", diff, 8'h00);
    check("mid_rst_bout", 8'(bout), 8'd0);
    check("mid_rst_done", 8'(done), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_diff = 8'h00;
    run_op("dc8_32", 8'hC8, 8'h32);

    for (int i = 0; i < 16; i++) begin
      run_op("rand", 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
